// File: rtl/divider_result_collector.sv
// ---------------------------------------------------------------------------
// divider_result_collector
//
// Purpose:
//   Sits downstream of the fixed-latency, non-stallable pipelined Divider.
//   Every operation accepted from the issuer is tracked through a delay line
//   that matches the divider latency. When an operation reaches the end of
//   that line, the divider outputs are sampled and written into a small
//   in-order output FIFO, which has a ready/valid interface.
//   A credit counter throttles the issuer. Because of it, the FIFO can never
//   be asked to hold more results than it has entries, even though the
//   divider itself cannot be stalled.
//
// Optional feature macro:
//   DIVCOL_STATS_EN - when defined, adds the result_count and div_zero_count
//                     output ports. Both are saturating 16-bit pop counters.
//
// Ports:
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   issue_valid/ready     issuer handshake; an operation fires on valid&&ready
//   issue_divisor         divisor being sent to the divider (checked for zero)
//   issue_dividend        dividend being sent to the divider (kept for div-by-zero)
//   issue_tag             user tag returned with the result
//   div_quotient          divider quotient_final output
//   div_remainder         divider remainder output
//   out_valid/ready       consumer handshake on the FIFO head
//   out_quotient          head quotient (all ones for div-by-zero)
//   out_remainder         head remainder (zero-extended dividend for div-by-zero)
//   out_tag               head tag
//   out_div_zero          head came from a zero divisor
//   credit_count          operations issued and not yet popped
//   result_count          (DIVCOL_STATS_EN) results popped, saturating
//   div_zero_count        (DIVCOL_STATS_EN) div-by-zero results popped, saturating
// ---------------------------------------------------------------------------
module divider_result_collector #(
   parameter int DIVISOR_BITS  = 8,
   parameter int DIVIDEND_BITS = 16,
   parameter int REM_BITS      = 23,
   parameter int LATENCY       = 18,
   parameter int FIFO_DEPTH    = 4,
   parameter int TAG_BITS      = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic [DIVISOR_BITS-1:0]           issue_divisor,
   input  logic [DIVIDEND_BITS-1:0]          issue_dividend,
   input  logic [TAG_BITS-1:0]               issue_tag,
   input  logic [DIVIDEND_BITS-1:0]          div_quotient,
   input  logic [REM_BITS-1:0]               div_remainder,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DIVIDEND_BITS-1:0]          out_quotient,
   output logic [REM_BITS-1:0]               out_remainder,
   output logic [TAG_BITS-1:0]               out_tag,
   output logic                              out_div_zero,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   credit_count
`ifdef DIVCOL_STATS_EN
   ,
   output logic [15:0]                       result_count,
   output logic [15:0]                       div_zero_count
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   // ------------------------------------------------------------------
   // Handshake qualifiers
   // ------------------------------------------------------------------
   logic issueFire;
   logic capture;
   logic pop;

   // ------------------------------------------------------------------
   // Delay line: one stage per divider pipeline stage
   // ------------------------------------------------------------------
   logic [LATENCY-1:0]       lineValid_q;
   logic [TAG_BITS-1:0]      lineTag_q      [LATENCY];
   logic [DIVIDEND_BITS-1:0] lineDividend_q [LATENCY];
   logic                     lineDivZero_q  [LATENCY];

   // ------------------------------------------------------------------
   // Output FIFO storage and bookkeeping
   // ------------------------------------------------------------------
   logic [DIVIDEND_BITS-1:0] memQuot_q [FIFO_DEPTH];
   logic [REM_BITS-1:0]      memRem_q  [FIFO_DEPTH];
   logic [TAG_BITS-1:0]      memTag_q  [FIFO_DEPTH];
   logic                     memDz_q   [FIFO_DEPTH];

   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] fifoCount_q, fifoCount_d;
   logic [CNT_W-1:0] creditCount_q, creditCount_d;

   // Capture data after the div-by-zero substitution
   logic [DIVIDEND_BITS-1:0] capQuot;
   logic [REM_BITS-1:0]      capRem;

   // Wraps a FIFO pointer at FIFO_DEPTH. The depth need not be a power of two.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH-1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // The issuer is only ready while credits remain. A credit is returned only
   // when a result leaves the FIFO. This bounds FIFO occupancy plus in-flight
   // operations by FIFO_DEPTH.
   assign issue_ready = (creditCount_q < CNT_W'(FIFO_DEPTH));
   assign issueFire   = issue_valid && issue_ready;
   assign capture     = lineValid_q[LATENCY-1];
   assign out_valid   = (fifoCount_q != '0);
   assign pop         = out_valid && out_ready;
   assign credit_count = creditCount_q;

   // The head is presented straight from storage. It is forced to zero while
   // the FIFO is empty, so the outputs read zero after reset and never show
   // stale entries.
   always_comb begin
      out_quotient  = '0;
      out_remainder = '0;
      out_tag       = '0;
      out_div_zero  = 1'b0;
      if (out_valid) begin
         out_quotient  = memQuot_q[rdPtr_q];
         out_remainder = memRem_q[rdPtr_q];
         out_tag       = memTag_q[rdPtr_q];
         out_div_zero  = memDz_q[rdPtr_q];
      end
   end

   // On a zero divisor the divider output is meaningless. It is replaced by an
   // all-ones quotient and the original dividend as the remainder.
   always_comb begin
      capQuot = div_quotient;
      capRem  = div_remainder;
      if (lineDivZero_q[LATENCY-1]) begin
         capQuot = '1;
         capRem  = {{(REM_BITS-DIVIDEND_BITS){1'b0}}, lineDividend_q[LATENCY-1]};
      end
   end

   // Valid bits of the delay line. Only these need reset: clearing them is
   // what makes the results of pre-reset operations invisible. The reset
   // branch also wins over an issue fire in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         lineValid_q <= '0;
      end else begin
         lineValid_q[0] <= issueFire;
         for (int i = 1; i < LATENCY; i++) begin
            lineValid_q[i] <= lineValid_q[i-1];
         end
      end
   end

   // Payload of the delay line. It shifts every edge in lockstep with the
   // divider, whether or not the stage holds a tracked operation.
   always_ff @(posedge clock) begin
      lineTag_q[0]      <= issue_tag;
      lineDividend_q[0] <= issue_dividend;
      lineDivZero_q[0]  <= (issue_divisor == '0);
      for (int i = 1; i < LATENCY; i++) begin
         lineTag_q[i]      <= lineTag_q[i-1];
         lineDividend_q[i] <= lineDividend_q[i-1];
         lineDivZero_q[i]  <= lineDivZero_q[i-1];
      end
   end

   // FIFO storage writes. The contents need no reset because the head is
   // masked whenever the count is zero.
   always_ff @(posedge clock) begin
      if (capture) begin
         memQuot_q[wrPtr_q] <= capQuot;
         memRem_q[wrPtr_q]  <= capRem;
         memTag_q[wrPtr_q]  <= lineTag_q[LATENCY-1];
         memDz_q[wrPtr_q]   <= lineDivZero_q[LATENCY-1];
      end
   end

   // Next-state for the FIFO pointers, the occupancy and the credit counter.
   // A simultaneous capture and pop keeps the occupancy unchanged, including
   // when the FIFO is full. A simultaneous fire and pop likewise leaves the
   // credits unchanged.
   always_comb begin
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      fifoCount_d   = fifoCount_q;
      creditCount_d = creditCount_q;
      if (capture) begin
         wrPtr_d = nextPtr(wrPtr_q);
      end
      if (pop) begin
         rdPtr_d = nextPtr(rdPtr_q);
      end
      unique case ({capture, pop})
         2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
         2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
         default: fifoCount_d = fifoCount_q;
      endcase
      unique case ({issueFire, pop})
         2'b10:   creditCount_d = creditCount_q + CNT_W'(1);
         2'b01:   creditCount_d = creditCount_q - CNT_W'(1);
         default: creditCount_d = creditCount_q;
      endcase
   end

   // FIFO and credit state registers. Reset empties the FIFO and returns all
   // credits.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         fifoCount_q   <= '0;
         creditCount_q <= '0;
      end else begin
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         fifoCount_q   <= fifoCount_d;
         creditCount_q <= creditCount_d;
      end
   end

   // Credit accounting should make a capture into a full FIFO impossible.
   // If one ever happens, a result has been lost, so it is flagged loudly.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(capture && !pop && (fifoCount_q == CNT_W'(FIFO_DEPTH))))
            else $error("divider_result_collector: capture into full FIFO");
      end
   end

`ifdef DIVCOL_STATS_EN
   logic [15:0] resultCount_q;
   logic [15:0] divZeroCount_q;

   // Pop statistics. Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         resultCount_q  <= '0;
         divZeroCount_q <= '0;
      end else if (pop) begin
         if (resultCount_q != 16'hFFFF) begin
            resultCount_q <= resultCount_q + 16'd1;
         end
         if (out_div_zero && (divZeroCount_q != 16'hFFFF)) begin
            divZeroCount_q <= divZeroCount_q + 16'd1;
         end
      end
   end

   assign result_count   = resultCount_q;
   assign div_zero_count = divZeroCount_q;
`endif

endmodule

// File: tb/tb_divider_result_collector.sv
// ---------------------------------------------------------------------------
// tb_divider_result_collector
//
// Bench for divider_result_collector. A small behavioural model of the
// fixed-latency divider feeds div_quotient/div_remainder. For a zero divisor
// the model deliberately produces garbage. The issue side pushes expected
// results into a queue, and a monitor at the falling edge pops and compares
// whenever the DUT presents a result that the consumer accepts.
// ---------------------------------------------------------------------------
module tb_divider_result_collector;

   localparam int DIVISOR_BITS  = 8;
   localparam int DIVIDEND_BITS = 16;
   localparam int REM_BITS      = 23;
   localparam int LATENCY       = 18;
   localparam int FIFO_DEPTH    = 4;
   localparam int TAG_BITS      = 4;

   typedef struct packed {
      logic [DIVIDEND_BITS-1:0] quot;
      logic [REM_BITS-1:0]      rem;
      logic [TAG_BITS-1:0]      tag;
      logic                     dz;
   } exp_t;

   logic                       clock;
   logic                       reset;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [DIVISOR_BITS-1:0]    issue_divisor;
   logic [DIVIDEND_BITS-1:0]   issue_dividend;
   logic [TAG_BITS-1:0]        issue_tag;
   logic [DIVIDEND_BITS-1:0]   div_quotient;
   logic [REM_BITS-1:0]        div_remainder;
   logic                       out_valid;
   logic                       out_ready;
   logic [DIVIDEND_BITS-1:0]   out_quotient;
   logic [REM_BITS-1:0]        out_remainder;
   logic [TAG_BITS-1:0]        out_tag;
   logic                       out_div_zero;
   logic [$clog2(FIFO_DEPTH+1)-1:0] credit_count;
`ifdef DIVCOL_STATS_EN
   logic [15:0]                result_count;
   logic [15:0]                div_zero_count;
`endif

   int   checks = 0;
   int   errors = 0;
   int   mCredits = 0;
   exp_t expQ[$];

   // Stall-stability tracking for the monitor
   logic prevStall = 1'b0;
   exp_t prevHead;

   divider_result_collector #(
      .DIVISOR_BITS (DIVISOR_BITS),
      .DIVIDEND_BITS(DIVIDEND_BITS),
      .REM_BITS     (REM_BITS),
      .LATENCY      (LATENCY),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .TAG_BITS     (TAG_BITS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_divisor (issue_divisor),
      .issue_dividend(issue_dividend),
      .issue_tag     (issue_tag),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_tag       (out_tag),
      .out_div_zero  (out_div_zero),
      .credit_count  (credit_count)
`ifdef DIVCOL_STATS_EN
      ,
      .result_count  (result_count),
      .div_zero_count(div_zero_count)
`endif
   );

   // 10-unit clock period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural divider: samples operands on every edge and presents the
   // result of the operands sampled LATENCY edges earlier. A zero divisor
   // yields junk, which the DUT must not pass through.
   logic [DIVIDEND_BITS-1:0] dq [LATENCY];
   logic [REM_BITS-1:0]      dr [LATENCY];

   always @(posedge clock) begin
      for (int i = LATENCY-1; i > 0; i--) begin
         dq[i] <= dq[i-1];
         dr[i] <= dr[i-1];
      end
      if (issue_divisor == '0) begin
         dq[0] <= 16'h5A5A;
         dr[0] <= 23'h2BCDEF;
      end else begin
         dq[0] <= issue_dividend / DIVIDEND_BITS'(issue_divisor);
         dr[0] <= REM_BITS'(issue_dividend % DIVIDEND_BITS'(issue_divisor));
      end
   end

   assign div_quotient  = dq[LATENCY-1];
   assign div_remainder = dr[LATENCY-1];

   // Arithmetic reference for the collector's result
   function automatic exp_t expectFor(input logic [DIVISOR_BITS-1:0] dvs,
                                      input logic [DIVIDEND_BITS-1:0] dvd,
                                      input logic [TAG_BITS-1:0] tg);
      exp_t e;
      e.tag = tg;
      if (dvs == '0) begin
         e.quot = 16'hFFFF;
         e.rem  = {7'd0, dvd};
         e.dz   = 1'b1;
      end else begin
         e.quot = dvd / DIVIDEND_BITS'(dvs);
         e.rem  = REM_BITS'(dvd % DIVIDEND_BITS'(dvs));
         e.dz   = 1'b0;
      end
      return e;
   endfunction

   // One comparison: counts it, and reports it if it differs
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Presents one operation and holds it until the credit model says it fires.
   // Called just after a rising edge; returns just after the firing edge.
   task automatic applyStimulus(input logic [DIVISOR_BITS-1:0] dvs,
                                input logic [DIVIDEND_BITS-1:0] dvd,
                                input logic [TAG_BITS-1:0] tg);
      int  n;
      logic willFire;
      issue_divisor  = dvs;
      issue_dividend = dvd;
      issue_tag      = tg;
      issue_valid    = 1'b1;
      n = 0;
      do begin
         willFire = (mCredits < FIFO_DEPTH);
         @(posedge clock);
         #2;
         n++;
      end while (!willFire && n < 200);
      if (!willFire) begin
         checks++;
         errors++;
         $display("[TB] FAIL issue_timeout: tag 0x%0h never accepted", tg);
      end
      issue_valid = 1'b0;
   endtask

   // Waits, with a bound, until every expected result has been consumed
   task automatic waitDrain(input int bound);
      int n = 0;
      while (expQ.size() != 0 && n < bound) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", expQ.size());
      end
   endtask

   // Monitor and scoreboard. Inputs change only just after a rising edge, so
   // the falling edge sees what the next rising edge will act on.
   always @(negedge clock) begin
      logic popNow;
      logic fireNow;
      exp_t e;
      if (reset) begin
         expQ.delete();
         mCredits  = 0;
         prevStall = 1'b0;
      end else begin
         checkOutput("issue_ready", 32'(issue_ready), 32'(mCredits < FIFO_DEPTH));
         checkOutput("credit_count", 32'(credit_count), 32'(mCredits));
         if (prevStall) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_quot", 32'(out_quotient), 32'(prevHead.quot));
            checkOutput("stall_rem", 32'(out_remainder), 32'(prevHead.rem));
            checkOutput("stall_tag", 32'(out_tag), 32'(prevHead.tag));
            checkOutput("stall_dz", 32'(out_div_zero), 32'(prevHead.dz));
         end
         popNow = out_valid && out_ready;
         if (popNow) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_result: tag 0x%0h presented, none expected", out_tag);
            end else begin
               e = expQ.pop_front();
               checkOutput("result_quot", 32'(out_quotient), 32'(e.quot));
               checkOutput("result_rem", 32'(out_remainder), 32'(e.rem));
               checkOutput("result_tag", 32'(out_tag), 32'(e.tag));
               checkOutput("result_dz", 32'(out_div_zero), 32'(e.dz));
            end
         end
         fireNow = issue_valid && (mCredits < FIFO_DEPTH);
         if (fireNow) begin
            expQ.push_back(expectFor(issue_divisor, issue_dividend, issue_tag));
         end
         mCredits = mCredits + int'(fireNow) - int'(popNow);
         prevStall     = out_valid && !out_ready;
         prevHead.quot = out_quotient;
         prevHead.rem  = out_remainder;
         prevHead.tag  = out_tag;
         prevHead.dz   = out_div_zero;
      end
   end

   // Directed vectors for the bulk run: divisor, dividend, tag
   logic [DIVISOR_BITS-1:0]  vecDvs [10] = '{8'd13, 8'd0, 8'd255, 8'd1, 8'd9,
                                             8'd0, 8'd200, 8'd3, 8'd17, 8'd128};
   logic [DIVIDEND_BITS-1:0] vecDvd [10] = '{16'd50000, 16'd777, 16'd65535, 16'd4321, 16'd8,
                                             16'hFFFF, 16'd40000, 16'd0, 16'd12345, 16'd65535};

   initial begin
      int lat;
      int seen;
      logic found;

      reset          = 1'b1;
      issue_valid    = 1'b0;
      issue_divisor  = '0;
      issue_dividend = '0;
      issue_tag      = '0;
      out_ready      = 1'b0;

      // Reset for two cycles, then check the idle state
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_issue_ready", 32'(issue_ready), 32'd1);
      checkOutput("rst_credit", 32'(credit_count), 32'd0);
      checkOutput("rst_quot", 32'(out_quotient), 32'd0);
      checkOutput("rst_rem", 32'(out_remainder), 32'd0);
      checkOutput("rst_tag", 32'(out_tag), 32'd0);
      checkOutput("rst_dz", 32'(out_div_zero), 32'd0);

      // 100 / 7 = 14 r 2. out_valid must first appear LATENCY edges after the
      // issue edge, i.e. in the cycle following the capture edge.
      @(posedge clock);
      #2 out_ready = 1'b1;
      applyStimulus(8'd7, 16'd100, 4'd3);
      lat = 0;
      found = 1'b0;
      while (!found && lat < 100) begin
         @(negedge clock);
         if (out_valid) found = 1'b1;
         else lat++;
      end
      checkOutput("basic_latency", 32'(lat), 32'(LATENCY));
      checkOutput("basic_quot", 32'(out_quotient), 32'd14);
      checkOutput("basic_rem", 32'(out_remainder), 32'd2);
      checkOutput("basic_tag", 32'(out_tag), 32'd3);
      checkOutput("basic_dz", 32'(out_div_zero), 32'd0);
      waitDrain(50);
      @(negedge clock);
      checkOutput("basic_credit_back", 32'(credit_count), 32'd0);

      // Divide by zero: fixed quotient, dividend as the remainder
      @(posedge clock);
      #2;
      applyStimulus(8'd0, 16'h1234, 4'd5);
      found = 1'b0;
      lat = 0;
      while (!found && lat < 100) begin
         @(negedge clock);
         if (out_valid) found = 1'b1;
         else lat++;
      end
      checkOutput("dz_found", 32'(found), 32'd1);
      checkOutput("dz_quot", 32'(out_quotient), 32'hFFFF);
      checkOutput("dz_rem", 32'(out_remainder), 32'h001234);
      checkOutput("dz_tag", 32'(out_tag), 32'd5);
      checkOutput("dz_flag", 32'(out_div_zero), 32'd1);
      waitDrain(50);

      // Back-pressure: six attempts with the consumer stalled, only four fit
      @(posedge clock);
      #2 out_ready = 1'b0;
      for (int t = 0; t < 6; t++) begin
         issue_divisor  = DIVISOR_BITS'(t + 3);
         issue_dividend = DIVIDEND_BITS'(1000 + t * 777);
         issue_tag      = TAG_BITS'(t);
         issue_valid    = 1'b1;
         @(posedge clock);
         #2;
      end
      issue_valid = 1'b0;
      repeat (25) @(negedge clock);
      checkOutput("bp_credit", 32'(credit_count), 32'd4);
      checkOutput("bp_issue_ready", 32'(issue_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_head_tag", 32'(out_tag), 32'd0);
      checkOutput("bp_head_quot", 32'(out_quotient), 32'd333);
      @(posedge clock);
      #2 out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checkOutput("bp_ready_back", 32'(issue_ready), 32'd1);
      waitDrain(50);

      // Reset with three operations in flight, plus an issue during reset
      @(posedge clock);
      #2;
      applyStimulus(8'd5, 16'd500, 4'd10);
      applyStimulus(8'd6, 16'd600, 4'd11);
      applyStimulus(8'd7, 16'd700, 4'd12);
      repeat (4) @(posedge clock);
      #2;
      reset          = 1'b1;
      issue_valid    = 1'b1;
      issue_divisor  = 8'd2;
      issue_dividend = 16'd42;
      issue_tag      = 4'd13;
      @(posedge clock);
      #2;
      reset       = 1'b0;
      issue_valid = 1'b0;
      seen = 0;
      repeat (30) begin
         @(negedge clock);
         if (out_valid) seen++;
      end
      checkOutput("rst_mid_out_valid", 32'(seen), 32'd0);
      checkOutput("rst_mid_credit", 32'(credit_count), 32'd0);

      // Bulk run, credit-limited, including two zero divisors
      @(posedge clock);
      #2;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecDvs[i], vecDvd[i], TAG_BITS'(i + 1));
      end
      waitDrain(300);
      @(negedge clock);
      checkOutput("bulk_credit", 32'(credit_count), 32'd0);
`ifdef DIVCOL_STATS_EN
      checkOutput("stats_results", 32'(result_count), 32'd10);
      checkOutput("stats_div_zero", 32'(div_zero_count), 32'd2);
`endif

      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider_result_collector.md
Name: divider_result_collector

Overview:
Downstream companion to the pipelined Divider (8-bit divisor, 16-bit dividend, 16-bit quotient_final, 23-bit remainder, fixed latency, no stall). It tracks each issued operation with a valid/tag/dividend delay line matched to the divider latency. It captures the divider outputs into an output FIFO with a ready/valid interface. It back-pressures the issuer by credit counting so the non-stallable pipeline can never overflow the FIFO.

Parameters:
DIVISOR_BITS, 8, divisor width
DIVIDEND_BITS, 16, dividend and quotient width
REM_BITS, 23, remainder width (DIVISOR_BITS+DIVIDEND_BITS-1)
LATENCY, 18, edges from operand sample to result valid on divider outputs (DIVIDEND_BITS+2); >=1
FIFO_DEPTH, 4, output FIFO entries; >=2
TAG_BITS, 4, user tag width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
issue_valid  in  1  upstream is presenting operands to the divider this cycle
issue_ready  out  1  credit available; the issue fires on a rising edge when valid&&ready
issue_divisor  in  DIVISOR_BITS  same value driven to the divider divisor
issue_dividend  in  DIVIDEND_BITS  same value driven to the divider dividend
issue_tag  in  TAG_BITS  user tag, returned with the result
div_quotient  in  DIVIDEND_BITS  from divider quotient_final
div_remainder  in  REM_BITS  from divider remainder
out_valid  out  1  FIFO head holds a result
out_ready  in  1  consumer accepts the head
out_quotient  out  DIVIDEND_BITS  result quotient
out_remainder  out  REM_BITS  result remainder
out_tag  out  TAG_BITS  tag of the result
out_div_zero  out  1  the result came from divisor==0
credit_count  out  $clog2(FIFO_DEPTH+1)  operations issued and not yet popped

Behaviour:
- Reset values: out_valid=0, credit_count=0, issue_ready=1. out_quotient, out_remainder, out_tag and out_div_zero are all 0.
- Issue fire: issue_valid&&issue_ready at edge k. Delay-line stage 0 loads valid=1, tag, dividend and div_zero=(issue_divisor==0). The line shifts every edge unconditionally and has LATENCY stages.
- Capture: at edge k+LATENCY, the last stage is valid. The FIFO writes {div_quotient, div_remainder, tag, div_zero}, sampled at that edge.
- Div-by-zero: the divider outputs are ignored. The stored quotient is all ones (0xFFFF). The stored remainder is the zero-extended dividend. out_div_zero=1.
- FIFO: registered storage, head presented directly, in-order. There is no bypass, so out_valid rises in the cycle after the capture edge. Minimum issue-to-out_valid is LATENCY edges plus that cycle.
- Output handshake: pop on out_valid&&out_ready. While out_valid&&!out_ready, all out_* stay stable. Capture and pop in the same edge is legal at any occupancy, including full.
- Credits: credit_count increments on issue fire and decrements on pop. Simultaneous fire and pop leaves it unchanged. issue_ready = (credit_count < FIFO_DEPTH), combinational from the register.
- Overflow: credits guarantee FIFO occupancy plus in-flight operations never exceeds FIFO_DEPTH. A capture into a full FIFO is therefore impossible; a simulation assertion flags it.
- Back-to-back: one issue per cycle is sustained while out_ready=1 and FIFO_DEPTH >= LATENCY+1. Otherwise throughput is credit-limited.
- issue_valid while !issue_ready: nothing is recorded. The upstream must hold its operands. Results the divider produces for unrecorded operands are discarded.
- Reset mid-operation:
  - All delay-line valids are cleared, the FIFO is emptied and credit_count goes to 0.
  - Results of in-flight operations emerging from the unreset divider are ignored because their valids are cleared.
  - An issue fire in the reset cycle is ignored.
- credit_count never wraps: it is bounded 0..FIFO_DEPTH by construction.

Optional Feature:
DIVCOL_STATS_EN:
- Defined: adds two output ports, result_count[15:0] and div_zero_count[15:0].
- result_count increments on each pop; div_zero_count increments on each pop with out_div_zero=1.
- Both are saturating at 0xFFFF and cleared by reset.
- Undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset for 2 cycles -> out_valid=0, issue_ready=1, credit_count=0, all out_* zero.
- Issue divisor=7, dividend=100, tag=3 with out_ready=1 and the real Divider attached -> out_valid in the cycle after edge k+18: quotient=14, remainder=2, tag=3, div_zero=0; credit_count returns to 0 after the pop.
- Issue divisor=0, dividend=0x1234, tag=5 -> quotient=0xFFFF, remainder=0x001234, tag=5, div_zero=1.
- out_ready=0 with 6 consecutive issue_valid and tags 0..5 -> only tags 0..3 are accepted, issue_ready=0 and credit_count=4, outputs stay stable. Then out_ready=1 -> tags 0,1,2,3 pop in order with correct results, and issue_ready reasserts after the first pop.
- Issue 3 operations, assert reset for 1 cycle 5 cycles later, then idle for 30 cycles -> out_valid stays 0 and credit_count=0.
- With DIVCOL_STATS_EN, 10 random issues including 2 with divisor=0, all popped -> result_count=10, div_zero_count=2, and every result matches dividend/divisor and dividend%divisor.
